uart_tx: RTL
============

# uart_tx

UART transmitter that serialises one parallel word per handshake onto a single `tx` line: start bit, data LSB first, optional parity, then stop bit(s). It is the transmit counterpart of the receiver in the I2C/ADS1115 demo path and uses the same framing parameters and oversampled bit timing. `clk_in` is the oversampling tick clock, so each bit lasts OVERSAMPLING cycles.

## Interface
- DATA_BITS, 8: data bits per frame (1..16).
- STOP_BITS, 1: stop bits per frame (1 or 2).
- OVERSAMPLING, 16: `clk_in` cycles per bit (≥2).
- ODD_PARITY, 0: 1 selects odd parity, 0 selects even. Only used when UART_TX_PARITY_EN is defined.

- clk_in  in  1  clock (oversampling tick rate)
- n_rst  in  1  reset, asynchronous, active-low
- valid_in  in  1  word on data_in is offered
- data_in  in  DATA_BITS  word to send
- ready_out  out  1  transmitter can accept a word
- busy_out  out  1  frame in progress
- done_out  out  1  one-cycle pulse when the last stop bit completes
- tx  out  1  serial line, idle high

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- Accept: a word is accepted when `valid_in && ready_out` is high at a rising edge.
  - data_in is captured into a shift register; later changes to data_in are ignored.
  - `valid_in` is ignored while `ready_out` is 0.
- IDLE -> START on accept.
- START -> DATA after OVERSAMPLING cycles.
- DATA shifts the register right every OVERSAMPLING cycles; bit counter 0..DATA_BITS-1.
  - After bit DATA_BITS-1: go to PARITY, or to STOP if the macro is off.
- PARITY -> STOP after OVERSAMPLING cycles.
- STOP -> IDLE after OVERSAMPLING*STOP_BITS cycles.
- tx is registered (no glitches):
  - START = 0
  - DATA = shift_reg[0]
  - PARITY = parity bit
  - STOP/IDLE = 1
- Cycle counter width: $clog2(OVERSAMPLING*STOP_BITS); it clears on every state change.
- Bit counter width: $clog2(DATA_BITS), minimum 1.
- Reset values: tx=1, ready_out=0, busy_out=0, done_out=0, state IDLE, counters 0, shift register 0.
- ready_out rises on the first clock edge after reset is released.
- Reset mid-frame: tx returns to 1 immediately (asynchronous); the partial frame is abandoned and never resumed.

## Timing
- Definitions:
  - E0 = accept edge.
  - P = 1 if parity is compiled in, else 0.
  - F = 1 + DATA_BITS + P + STOP_BITS.
- At E0: tx<=0, ready_out<=0, busy_out<=1.
- Data bit i is driven from E0+(1+i)*OVERSAMPLING for OVERSAMPLING cycles.
- Parity bit is driven from E0+(1+DATA_BITS)*OVERSAMPLING.
- Stop starts at E0+(1+DATA_BITS+P)*OVERSAMPLING.
- At Ef = E0+F*OVERSAMPLING: state IDLE, done_out=1 for exactly one cycle, busy_out=0, ready_out=1, tx stays 1.
- Earliest next accept is Ef+1, so back-to-back frames are separated by exactly one extra idle-high cycle.
- Throughput: one word per F*OVERSAMPLING+1 cycles.

## Configuration
- UART_TX_PARITY_EN defined:
  - PARITY state is present; one parity bit is sent between data and stop.
  - Even parity = ^data; odd parity = ~^data, computed on the captured word.
- UART_TX_PARITY_EN undefined:
  - No PARITY state; ODD_PARITY is ignored.
  - Frame is start + data + stop, matching the receiver's framing.

## Structure
- Shared package uart_pkg holds:
  - state encodings (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4; 3-bit state);
  - a frame-length function F(DATA_BITS, STOP_BITS, parity) for benches.
- One sub-module, uart_bit_timer:
  - cycle counter with a load/clear input and a terminal-count output for a programmable length (OVERSAMPLING or OVERSAMPLING*STOP_BITS).
- The FSM, shift register and output registers stay in uart_tx.

## Test plan
All scenarios use OVERSAMPLING=16, DATA_BITS=8.
- Send 0xA5, STOP_BITS=1, no parity -> tx reads 0 then 1,0,1,0,0,1,0,1 then 1, 16 cycles each; done_out pulses at E0+160; ready_out high at E0+160.
- 0x00 then 0xFF with valid_in held high -> second start edge at E0+161; tx high for exactly 17 cycles between the last data bit and the second start bit.
- valid_in=1, data_in=0x3C while busy; change data_in to 0x55 mid-frame -> no extra accept; transmitted byte stays 0x3C.
- Assert n_rst low at E0+50 -> tx=1 immediately, busy_out=0; ready_out returns 1 one edge after release; no done_out pulse.
- With UART_TX_PARITY_EN: send 0x07 -> parity bit 1 (even); with ODD_PARITY=1 -> 0; done_out at E0+176.
- STOP_BITS=2, send 0x81 -> stop level held 32 cycles; done_out at E0+176.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   uart_state_e : 3-bit FSM state encoding used by uart_tx
//   frame_len()  : frame length in bit periods (start + data + parity + stop),
//                  used by benches to compute expected done_out timing.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_PARITY = 3'd4
    } uart_state_e;

    function automatic int frame_len(input int data_bits, input int stop_bits, input int parity);
        return 1 + data_bits + parity + stop_bits;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period cycle counter for uart_tx.
// Ports:
//   clk_in   : oversampling tick clock
//   n_rst    : asynchronous active-low reset
//   clear_i  : forces the counter back to 0 on the next edge
//   last_i   : terminal count (period length - 1)
//   tc_o     : high during the last cycle of the current period
// The counter wraps to 0 by itself after terminal count, so consecutive
// periods of the same length need no explicit clear.
module uart_bit_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk_in,
    input  logic             n_rst,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] last_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // tc must not depend on clear_i: the FSM derives clear from the state
    // change that tc itself triggers.
    assign tc_o = (cnt_q == last_i);

    always_comb begin
        cnt_d = cnt_q + WIDTH'(1);
        if (clear_i || tc_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional
// parity bit, STOP_BITS stop bits. Each bit lasts OVERSAMPLING clk_in cycles.
// Optional feature macro: UART_TX_PARITY_EN (adds the parity bit; ODD_PARITY
// selects odd when 1, even when 0).
// Ports:
//   clk_in    : oversampling tick clock
//   n_rst     : asynchronous active-low reset
//   valid_in  : word on data_in is offered
//   data_in   : word to send (captured on accept)
//   ready_out : transmitter can accept a word
//   busy_out  : frame in progress
//   done_out  : one-cycle pulse when the last stop bit completes
//   tx        : serial line, idle high
//
// state  | meaning
// IDLE   | line high, ready for a word
// START  | driving start bit (0)
// DATA   | driving shift_q[0], shifting right each bit period
// PARITY | driving parity bit (only with UART_TX_PARITY_EN)
// STOP   | driving stop level for STOP_BITS bit periods
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int OVERSAMPLING = 16,
    parameter int ODD_PARITY   = 0
) (
    input  logic                 clk_in,
    input  logic                 n_rst,
    input  logic                 valid_in,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 ready_out,
    output logic                 busy_out,
    output logic                 done_out,
    output logic                 tx
);

    localparam int CW = $clog2(OVERSAMPLING * STOP_BITS);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLING - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(OVERSAMPLING * STOP_BITS - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    if (DATA_BITS < 1 || DATA_BITS > 16 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        OVERSAMPLING < 2 || (ODD_PARITY != 0 && ODD_PARITY != 1)) begin : g_bad_cfg
        $error("uart_tx: unsupported parameter set");
    end

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tc;
    logic                 timer_clear;
    logic [CW-1:0]        timer_last;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    assign timer_last  = (state_q == ST_STOP) ? STOP_LAST : BIT_LAST;
    assign timer_clear = (state_d != state_q) || (state_q == ST_IDLE);

    uart_bit_timer #(.WIDTH(CW)) u_timer (
        .clk_in  (clk_in),
        .n_rst   (n_rst),
        .clear_i (timer_clear),
        .last_i  (timer_last),
        .tc_o    (tc)
    );

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (valid_in && ready_q) begin
                    state_d = ST_START;
                    shift_d = data_in;
                    bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                    par_d   = (ODD_PARITY != 0) ? ~^data_in : ^data_in;
`endif
                end
            end
            ST_START: begin
                if (tc) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (tc) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == LAST_BIT) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tc) state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (tc) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so tx changes exactly
        // on the bit boundary edge.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_in or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign tx        = tx_q;
    assign ready_out = ready_q;
    assign busy_out  = busy_q;
    assign done_out  = done_q;

endmodule
